// File: rtl/exec_mem_unit_pkg.sv
// rtl/exec_mem_unit_pkg.sv - shared ALU/access-size codes and memory sizing for exec_mem_unit
package exec_mem_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_OR   = 4'd2,
    ALU_AND  = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLL  = 4'd6,
    ALU_SRL  = 4'd7,
    ALU_SRA  = 4'd8,
    ALU_SLT  = 4'd9,
    ALU_SLTU = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    SZ_WORD = 2'b00,
    SZ_HALF = 2'b01,
    SZ_BYTE = 2'b10,
    SZ_NONE = 2'b11
  } mem_size_e;

  localparam int DM_WORDS_DEF = 4096;

endpackage

// File: rtl/exec_mem_be.sv
// rtl/exec_mem_be.sv - byte-lane enable decode from access size and byte offset
module exec_mem_be
  import exec_mem_unit_pkg::*;
(
  input  logic [1:0] i_hbw,
  input  logic [1:0] i_addr_lo,
  output logic [3:0] o_be
);

  always_comb begin
    o_be = 4'b0000;
    case (mem_size_e'(i_hbw))
      SZ_WORD: o_be = 4'b1111;
      SZ_HALF: o_be = i_addr_lo[1] ? 4'b1100 : 4'b0011;
      SZ_BYTE: o_be = 4'b0001 << i_addr_lo;
      default: o_be = 4'b0000;
    endcase
  end

endmodule

// File: rtl/exec_mem_unit.sv
// rtl/exec_mem_unit.sv - execute/memory slice: combinational ALU plus byte-writable data memory
module exec_mem_unit
  import exec_mem_unit_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEF,
  parameter int DM_AW    = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ALUOP,
  input  logic [31:0] Src1,
  input  logic [31:0] Src2,
  output logic [31:0] Result,
  input  logic [31:0] memAddr,
  input  logic [1:0]  hbw,
  input  logic        memWrite,
  input  logic [31:0] memData,
  input  logic [31:0] pc,
  output logic [3:0]  BE,
  output logic [31:0] dataOut
);

  logic [31:0]      r_mem [DM_WORDS];
  logic [DM_AW-1:0] w_idx;
  logic [31:0]      w_lane_data;
  logic [31:0]      w_merged;

  always_comb begin
    Result = 32'h0;
    case (alu_op_e'(ALUOP))
      ALU_ADD:  Result = Src1 + Src2;
      ALU_SUB:  Result = Src1 - Src2;
      ALU_OR:   Result = Src1 | Src2;
      ALU_AND:  Result = Src1 & Src2;
      ALU_XOR:  Result = Src1 ^ Src2;
      ALU_NOR:  Result = ~(Src1 | Src2);
      ALU_SLL:  Result = Src1 << Src2[4:0];
      ALU_SRL:  Result = Src1 >> Src2[4:0];
      ALU_SRA:  Result = $unsigned($signed(Src1) >>> Src2[4:0]);
      ALU_SLT:  Result = {31'h0, $signed(Src1) < $signed(Src2)};
      ALU_SLTU: Result = {31'h0, Src1 < Src2};
      ALU_LUI:  Result = {Src2[15:0], 16'h0};
      default:  Result = 32'h0;
    endcase
  end

  exec_mem_be u_be (
    .i_hbw     (hbw),
    .i_addr_lo (memAddr[1:0]),
    .o_be      (BE)
  );

  assign w_idx   = memAddr[DM_AW+1:2];
  assign dataOut = r_mem[w_idx];

  // Replicate right-aligned store data so every enabled lane sees its byte.
  always_comb begin
    w_lane_data = memData;
    case (mem_size_e'(hbw))
      SZ_BYTE: w_lane_data = {4{memData[7:0]}};
      SZ_HALF: w_lane_data = {2{memData[15:0]}};
      default: w_lane_data = memData;
    endcase
  end

  always_comb begin
    w_merged = r_mem[w_idx];
    for (int i = 0; i < 4; i++) begin
      if (BE[i]) w_merged[8*i +: 8] = w_lane_data[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DM_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (memWrite) begin
      r_mem[w_idx] <= w_merged;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset && memWrite && (BE != 4'b0000))
      $display("@%h: *%h <= %h", pc, {memAddr[31:2], 2'b00}, w_merged);
  end
`endif

endmodule

// File: tb/tb_exec_mem_unit.sv
// tb/tb_exec_mem_unit.sv - randomized self-checking bench with behavioural ALU/memory model
module tb_exec_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ALUOP;
  logic [31:0] Src1, Src2, Result;
  logic [31:0] memAddr;
  logic [1:0]  hbw;
  logic        memWrite;
  logic [31:0] memData, pc;
  logic [3:0]  BE;
  logic [31:0] dataOut;

  int n_total = 0;
  int n_bad   = 0;
  logic [31:0] mdl [4096];

  exec_mem_unit dut (
    .clk(clk), .reset(reset), .ALUOP(ALUOP), .Src1(Src1), .Src2(Src2),
    .Result(Result), .memAddr(memAddr), .hbw(hbw), .memWrite(memWrite),
    .memData(memData), .pc(pc), .BE(BE), .dataOut(dataOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0:  return a + b;
      1:  return a - b;
      2:  return a | b;
      3:  return a & b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return a << sh;
      7:  return a >> sh;
      8:  return $unsigned($signed(a) >>> sh);
      9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      10: return (a < b) ? 32'd1 : 32'd0;
      11: return b[15:0] * 32'h10000;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00: return 4;
      2'b01: return 2;
      2'b10: return 1;
      default: return 0;
    endcase
  endfunction

  // The access covers n naturally aligned bytes containing the addressed byte.
  function automatic logic [3:0] be_ref(input logic [1:0] sz, input logic [31:0] a);
    int n, start;
    logic [3:0] r;
    r = 4'b0;
    n = size_bytes(sz);
    if (n == 0) return r;
    start = int'(a % 4) / n * n;
    for (int k = start; k < start + n; k++) r[k] = 1'b1;
    return r;
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % 4096);
  endfunction

  task automatic model_store;
    int n, start;
    logic [31:0] w;
    n = size_bytes(hbw);
    if (!memWrite || n == 0) return;
    start = int'(memAddr % 4) / n * n;
    w = mdl[widx(memAddr)];
    for (int k = start; k < start + n; k++) w[8*k +: 8] = memData[8*(k-start) +: 8];
    mdl[widx(memAddr)] = w;
  endtask

  task automatic mem_op(input string tag, input logic [31:0] a, input logic [1:0] sz,
                        input logic we, input logic [31:0] d);
    memAddr = a; hbw = sz; memWrite = we; memData = d; pc = $urandom;
    #1;
    check({tag, "_be"}, {28'h0, BE}, {28'h0, be_ref(sz, a)});
    check({tag, "_pre"}, dataOut, mdl[widx(a)]);
    model_store();
    @(posedge clk); #1;
    check({tag, "_post"}, dataOut, mdl[widx(a)]);
    memWrite = 1'b0;
  endtask

  task automatic alu_chk(input string tag, input int op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
    ALUOP = op[3:0]; Src1 = a; Src2 = b;
    #1;
    check(tag, Result, exp);
  endtask

  initial begin
    reset = 1'b0; ALUOP = 4'd0; Src1 = 0; Src2 = 0;
    memAddr = 0; hbw = 2'b11; memWrite = 1'b0; memData = 0; pc = 0;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data", dataOut, 32'h0);
    check("rst_be_none", {28'h0, BE}, 32'h0);
    reset = 1'b1;
    @(posedge clk); #1;

    alu_chk("add",  0,  32'hFFFF_FFFE, 32'd2, 32'h0);
    alu_chk("sub",  1,  32'hFFFF_FFFE, 32'd2, 32'hFFFF_FFFC);
    alu_chk("slt",  9,  32'hFFFF_FFFE, 32'd2, 32'd1);
    alu_chk("sltu", 10, 32'hFFFF_FFFE, 32'd2, 32'd0);
    alu_chk("sra",  8,  32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFF);
    alu_chk("srl",  7,  32'hFFFF_FFFE, 32'd1, 32'h7FFF_FFFF);
    alu_chk("lui",  11, 32'hFFFF_FFFE, 32'h1234, 32'h1234_0000);
    alu_chk("op15", 15, 32'hDEAD_BEEF, 32'h1, 32'h0);

    mem_op("word", 32'h10, 2'b00, 1'b1, 32'h1122_3344);
    check("word_val", dataOut, 32'h1122_3344);
    mem_op("byte", 32'h12, 2'b10, 1'b1, 32'h0000_00AB);
    check("byte_val", dataOut, 32'h11AB_3344);
    mem_op("half", 32'h12, 2'b01, 1'b1, 32'h0000_BEEF);
    check("half_val", dataOut, 32'hBEEF_3344);
    mem_op("none", 32'h10, 2'b11, 1'b1, 32'hFFFF_FFFF);
    check("none_val", dataOut, 32'hBEEF_3344);

    mem_op("wrap", 32'h4000, 2'b00, 1'b1, 32'h5A5A_5A5A);
    memAddr = 32'h0; #1;
    check("wrap_lo", dataOut, 32'h5A5A_5A5A);
    memAddr = 32'h4000; #1;
    check("wrap_hi", dataOut, 32'h5A5A_5A5A);

    for (int it = 0; it < 400; it++) begin
      logic [31:0] a, b;
      int op;
      op = int'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      if (it % 4 == 0) b = b % 32;
      alu_chk("alu_rand", op, a, b, alu_ref(op, a, b));
      a = {$urandom_range(0, 3) == 0 ? 18'($urandom) : 18'h0, 8'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
      mem_op("mem_rand", a, 2'($urandom), 1'($urandom), $urandom);
    end

    mem_op("pre_rst", 32'h20, 2'b00, 1'b1, 32'hCAFE_F00D);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4096; i++) mdl[i] = 32'h0;
    #1;
    check("arst_now", dataOut, 32'h0);
    memAddr = 32'h10;   #1; check("arst_10", dataOut, 32'h0);
    memAddr = 32'h4000; #1; check("arst_4000", dataOut, 32'h0);
    memAddr = 32'h12; hbw = 2'b00; memWrite = 1'b1; memData = 32'h7777_7777;
    @(posedge clk); #1;
    check("rst_blk_wr", dataOut, 32'h0);
    memWrite = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    check("after_rst", dataOut, 32'h0);
    memAddr = 32'h20; #1;
    check("after_rst20", dataOut, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
